// File: rtl/alu_pkg.sv
// Shared types and sizing for the nibble-serial ALU responder.
// Slices are processed LSB first, so operation codes and sequencer states live here.
package alu_pkg;

  localparam int NIBBLE_W = 4;
  localparam int NIBBLES  = 8;

  typedef enum logic [2:0] {
    ADD,
    SUB,
    AND,
    OR,
    XOR,
    SLTU
  } AluCtrl;

  typedef enum logic [1:0] {
    IDLE,
    COUNT,
    DONE
  } AluSeqState;

endpackage

// File: rtl/nibble_alu.sv
// Combinational single-slice ALU: one NIBBLE_W-bit step of a wider operation.
module nibble_alu
  import alu_pkg::*;
#(
  parameter int W = NIBBLE_W
) (
  input  AluCtrl       op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         carry_in,
  output logic [W-1:0] y,
  output logic         carry_out
);

  logic [W-1:0] b_eff;
  logic [W:0]   sum;

  // Subtraction and unsigned compare share the inverted-operand adder chain.
  always_comb begin
    b_eff     = ((op == SUB) || (op == SLTU)) ? ~b : b;
    sum       = {1'b0, a} + {1'b0, b_eff} + {{W{1'b0}}, carry_in};
    y         = sum[W-1:0];
    carry_out = 1'b0;
    case (op)
      ADD, SUB, SLTU: begin
        y         = sum[W-1:0];
        carry_out = sum[W];
      end
      AND:     y = a & b;
      OR:      y = a | b;
      XOR:     y = a ^ b;
      default: y = sum[W-1:0];
    endcase
  end

endmodule

// File: rtl/nibble_serial_alu.sv
// Nibble-serial ALU responder: accepts a request, computes one slice per clock,
// then holds the result until the initiator drops its request.
module nibble_serial_alu
  import alu_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int NIBBLE_W = alu_pkg::NIBBLE_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  AluCtrl           ctrl,
  input  logic [WIDTH-1:0] word1,
  input  logic [WIDTH-1:0] word2,
  input  logic             perm_to_count,
  output logic             busy,
  output logic [2:0]       curr_nibble_idx,
  output logic [WIDTH-1:0] result
);

  localparam int SLICES = WIDTH / NIBBLE_W;

  AluSeqState          state;
  AluCtrl              ctrl_q;
  logic [WIDTH-1:0]    w1_q;
  logic [WIDTH-1:0]    w2_q;
  logic                carry_q;
  logic [2:0]          idx;
  logic [NIBBLE_W-1:0] a_s;
  logic [NIBBLE_W-1:0] b_s;
  logic [NIBBLE_W-1:0] y_s;
  logic                c_out;

  assign a_s = w1_q[idx*NIBBLE_W +: NIBBLE_W];
  assign b_s = w2_q[idx*NIBBLE_W +: NIBBLE_W];

  nibble_alu #(.W(NIBBLE_W)) u_slice (
    .op        (ctrl_q),
    .a         (a_s),
    .b         (b_s),
    .carry_in  (carry_q),
    .y         (y_s),
    .carry_out (c_out)
  );

  assign busy            = (state == COUNT);
  assign curr_nibble_idx = idx;

  // SLTU slices are only needed for their carry, so result is left untouched
  // until the final borrow is known.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      ctrl_q  <= ADD;
      w1_q    <= '0;
      w2_q    <= '0;
      carry_q <= 1'b0;
      idx     <= 3'd0;
      result  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (perm_to_count) begin
            ctrl_q  <= ctrl;
            w1_q    <= word1;
            w2_q    <= word2;
            idx     <= 3'd0;
            carry_q <= (ctrl == SUB) || (ctrl == SLTU);
            state   <= COUNT;
          end
        end
        COUNT: begin
          carry_q <= c_out;
          if (ctrl_q != SLTU) begin
            result[idx*NIBBLE_W +: NIBBLE_W] <= y_s;
          end
          if (idx == 3'(SLICES - 1)) begin
            if (ctrl_q == SLTU) begin
              result <= {{(WIDTH-1){1'b0}}, ~c_out};
            end
            idx   <= 3'd0;
            state <= DONE;
          end else begin
            idx <= idx + 3'd1;
          end
        end
        DONE: begin
          if (!perm_to_count) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_serial_alu.sv
// Scoreboard bench for nibble_serial_alu: expected results are queued at request
// time and checked when busy falls.
module tb_nibble_serial_alu;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  AluCtrl      ctrl = ADD;
  logic [31:0] word1 = '0;
  logic [31:0] word2 = '0;
  logic        perm_to_count = 1'b0;
  logic        busy;
  logic [2:0]  curr_nibble_idx;
  logic [31:0] result;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  nibble_serial_alu #(.WIDTH(32), .NIBBLE_W(4)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .ctrl            (ctrl),
    .word1           (word1),
    .word2           (word2),
    .perm_to_count   (perm_to_count),
    .busy            (busy),
    .curr_nibble_idx (curr_nibble_idx),
    .result          (result)
  );

  function automatic logic [31:0] model(AluCtrl op, logic [31:0] a, logic [31:0] b);
    case (op)
      ADD:     return a + b;
      SUB:     return a - b;
      AND:     return a & b;
      OR:      return a | b;
      XOR:     return a ^ b;
      SLTU:    return (a < b) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  task automatic drive_req(input AluCtrl op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    ctrl          = op;
    word1         = a;
    word2         = b;
    perm_to_count = 1'b1;
    exp_q.push_back(model(op, a, b));
  endtask

  // Waits for busy to rise and fall; optionally scrambles the inputs on a given busy cycle.
  task automatic wait_op(input int change_at, output int busy_cycles, output bit timed_out);
    busy_cycles = 0;
    timed_out   = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (busy) begin
        busy_cycles++;
        if (busy_cycles == change_at) begin
          word1 = 32'hDEADBEEF;
          word2 = 32'hDEADBEEF;
          ctrl  = XOR;
        end
      end else if (busy_cycles > 0) begin
        timed_out = 1'b0;
        break;
      end
    end
  endtask

  task automatic release_req();
    perm_to_count = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_busy got %b want 0", busy);
    end
    vectors++;
    if (curr_nibble_idx !== 3'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_idx got %0d want 0", curr_nibble_idx);
    end
    vectors++;
    if (result !== 32'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_result got %h want 00000000", result);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_add_basic();
    int          cycles;
    bit          done;
    logic [31:0] e;
    drive_req(ADD, 32'd0, 32'd123);
    cycles = 0;
    done   = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (busy) begin
        vectors++;
        if (curr_nibble_idx !== 3'(cycles)) begin
          miscompares++;
          $display("[TB] FAIL add_idx_seq got %0d want %0d", curr_nibble_idx, cycles);
        end
        cycles++;
      end else if (cycles > 0) begin
        done = 1'b1;
      end
    end
    vectors++;
    if (!done) begin
      miscompares++;
      $display("[TB] FAIL add_timeout got busy_cycles=%0d want busy to fall", cycles);
    end
    vectors++;
    if (cycles !== 8) begin
      miscompares++;
      $display("[TB] FAIL add_busy_len got %0d want 8", cycles);
    end
    e = exp_q.pop_front();
    vectors++;
    if (result !== e) begin
      miscompares++;
      $display("[TB] FAIL add_result got %h want %h", result, e);
    end
    release_req();
  endtask

  task automatic test_ops();
    AluCtrl      ops[9] = '{SUB, ADD, SLTU, SLTU, AND, OR, XOR, SLTU, ADD};
    logic [31:0] as[9]  = '{32'd5, 32'hFFFFFFFF, 32'd3, 32'd5, 32'hF0F0F0F0,
                            32'hF0F0F0F0, 32'hF0F0F0F0, 32'd7, 32'h0FFFFFFF};
    logic [31:0] bs[9]  = '{32'd7, 32'd1, 32'd5, 32'd3, 32'h0FF00FF0,
                            32'h0FF00FF0, 32'h0FF00FF0, 32'd7, 32'd1};
    int          cycles;
    bit          to;
    logic [31:0] e;
    for (int k = 0; k < 9; k++) begin
      drive_req(ops[k], as[k], bs[k]);
      wait_op(0, cycles, to);
      vectors++;
      if (to || cycles != 8) begin
        miscompares++;
        $display("[TB] FAIL op%0d_busy_len got %0d want 8", k, cycles);
      end
      e = exp_q.pop_front();
      vectors++;
      if (result !== e) begin
        miscompares++;
        $display("[TB] FAIL op%0d_%s_result got %h want %h", k, ops[k].name(), result, e);
      end
      release_req();
    end
  endtask

  task automatic test_held_request();
    int          cycles;
    int          extra_busy;
    bit          to;
    logic [31:0] e;
    drive_req(ADD, 32'h12345678, 32'h11111111);
    wait_op(0, cycles, to);
    e = exp_q.pop_front();
    vectors++;
    if (to || result !== e) begin
      miscompares++;
      $display("[TB] FAIL held_result got %h want %h", result, e);
    end
    extra_busy = 0;
    repeat (20) begin
      @(negedge clk);
      if (busy) extra_busy++;
    end
    vectors++;
    if (extra_busy !== 0) begin
      miscompares++;
      $display("[TB] FAIL held_reaccept got %0d busy cycles want 0", extra_busy);
    end
    vectors++;
    if (result !== e) begin
      miscompares++;
      $display("[TB] FAIL held_stable got %h want %h", result, e);
    end
    release_req();
    drive_req(OR, 32'h00FF0000, 32'h0000000F);
    wait_op(0, cycles, to);
    e = exp_q.pop_front();
    vectors++;
    if (to || result !== e) begin
      miscompares++;
      $display("[TB] FAIL rearm_result got %h want %h", result, e);
    end
    release_req();
  endtask

  task automatic test_operand_change();
    int          cycles;
    bit          to;
    logic [31:0] e;
    drive_req(SUB, 32'h00001000, 32'h00000001);
    wait_op(3, cycles, to);
    e = exp_q.pop_front();
    vectors++;
    if (to || result !== e) begin
      miscompares++;
      $display("[TB] FAIL latch_result got %h want %h", result, e);
    end
    release_req();
  endtask

  task automatic test_reset_mid();
    int          cycles;
    bit          to;
    bit          hit;
    logic [31:0] e;
    drive_req(ADD, 32'hAAAA5555, 32'h00001111);
    void'(exp_q.pop_front());
    hit = 1'b0;
    for (int i = 0; i < 40 && !hit; i++) begin
      @(negedge clk);
      if (busy && curr_nibble_idx == 3'd4) hit = 1'b1;
    end
    vectors++;
    if (!hit) begin
      miscompares++;
      $display("[TB] FAIL midrst_reach got no idx4 want idx4 while busy");
    end
    rst_n = 1'b0;
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL midrst_busy got %b want 0", busy);
    end
    vectors++;
    if (result !== 32'd0) begin
      miscompares++;
      $display("[TB] FAIL midrst_result got %h want 00000000", result);
    end
    vectors++;
    if (curr_nibble_idx !== 3'd0) begin
      miscompares++;
      $display("[TB] FAIL midrst_idx got %0d want 0", curr_nibble_idx);
    end
    rst_n = 1'b1;
    release_req();
    drive_req(ADD, 32'd2, 32'd2);
    wait_op(0, cycles, to);
    e = exp_q.pop_front();
    vectors++;
    if (to || result !== e || e !== 32'd4) begin
      miscompares++;
      $display("[TB] FAIL post_rst_add got %h want 00000004", result);
    end
    release_req();
  endtask

  initial begin
    test_reset();
    test_add_basic();
    test_ops();
    test_held_request();
    test_operand_change();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
